brp_gshare: RTL
===============

Name: brp_gshare

Overview:
- Parametrised successor to the single-table bimodal branch predictor in the fetch stage.
- Table of CTR_BITS-wide saturating counters, indexed by PC alone (bimodal mode) or PC XOR global history (gshare mode).
- Speculative global history register (GHR) with checkpoint/restore on mispredict; FSM-driven table-init sweep; saturating accuracy counters.
- Sits beside IF for predictions; the EX-stage branch resolution drives its update port.

Parameters:
IDX_BITS, 6, log2 of pattern-table depth (table has 2^IDX_BITS entries)
HIST_BITS, 6, GHR length; legal range 1..IDX_BITS
CTR_BITS, 2, counter width; legal range 1..4
MODE, 1, 0 = bimodal (index ignores GHR), 1 = gshare

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
pc_if  in  32  PC of the instruction in IF
opcode_if  in  7  opcode of the instruction in IF
b_imm  in  32  branch offset
j_imm  in  32  JAL offset
stall_if  in  1  IF held this cycle; no speculative GHR shift
ready  out  1  1 once the init sweep has finished
pred_valid  out  1  prediction emitted (branch or JAL)
pred_is_br  out  1  prediction came from the table (conditional branch)
pred_taken  out  1  predicted direction
pred_target  out  32  predicted next PC
pred_alt  out  32  the other path's next PC
pred_idx  out  IDX_BITS  table index used; carried down the pipe
pred_ghr  out  HIST_BITS  GHR value before this prediction; carried down the pipe
upd_valid  in  1  a branch resolved in EX this cycle
upd_idx  in  IDX_BITS  carried pred_idx
upd_ghr  in  HIST_BITS  carried pred_ghr
upd_taken  in  1  actual outcome
upd_mispredict  in  1  predicted direction was wrong
c_total  out  32  resolved-branch count
c_correct  out  32  correctly predicted branch count

Behaviour:

Index computation
- pc_idx = pc_if[IDX_BITS+1:2].
- MODE=1: idx = pc_idx XOR zero-extended GHR.
- MODE=0: idx = pc_idx.

State machine
- INIT: entered on any cycle with rst=0, including mid-operation.
  - Sweep pointer starts at 0 and writes the weakly-not-taken value, 2^(CTR_BITS-1)-1, to one entry per cycle after rst returns to 1.
  - After 2^IDX_BITS writes, move to RUN.
  - ready=0 throughout INIT.
- RUN: ready=1. Stays in RUN until the next reset.

Reset values
- All outputs 0.
- GHR 0, c_total 0, c_correct 0, sweep pointer 0.

Prediction (combinational, same cycle)
- opcode_if = op_br:
  - pred_valid=1, pred_is_br=1.
  - pred_taken = counter[idx] MSB; forced 0 while in INIT.
  - pred_target = taken ? pc_if+b_imm : pc_if+4; pred_alt = the other path.
- opcode_if = op_jal:
  - pred_valid=1, pred_is_br=0, pred_taken=1.
  - pred_target = pc_if+j_imm, pred_alt = pc_if+4.
- Any other opcode (JALR included): all pred_* outputs 0.
- pred_idx and pred_ghr always reflect the current idx and GHR.
- Additions wrap modulo 2^32.

Speculative GHR (registered)
- Shift GHR <= {GHR[HIST_BITS-2:0], pred_taken} when all hold: RUN, opcode_if = op_br, stall_if=0.
- For HIST_BITS=1, GHR <= pred_taken.

Mispredict restore (registered)
- When upd_valid & upd_mispredict in RUN: GHR <= {upd_ghr[HIST_BITS-2:0], upd_taken}.
- Restore has priority over a same-cycle IF shift.

Table update (registered, RUN only)
- When upd_valid: counter[upd_idx] increments if upd_taken, else decrements.
- Saturates at 2^CTR_BITS-1 and at 0.
- A same-cycle read of upd_idx returns the old value (no bypass).
- Updates in INIT are dropped.

Accuracy counters
- When upd_valid (either state): c_total += 1; c_correct += 1 if !upd_mispredict.
- Both saturate at 32'hFFFFFFFF.

Test Plan:
1. Reset and init: hold rst=0 for 3 cycles, then release with IDX_BITS=6 → ready=0 for exactly 64 cycles, then 1. Every entry reads 1 (CTR_BITS=2). A branch at pc 0x100 with b_imm 0x20 during INIT → pred_taken=0, target 0x104, alt 0x120.
2. Training (MODE=0): send 3 upd_valid with taken=1 to idx 5 → counter goes 1→2→3→3 (saturates). A branch at pc 0x14 then gives pred_taken=1, target 0x14+b_imm.
3. GHR and mispredict restore (MODE=1, HIST_BITS=4): predict taken 3 times with stall_if=0 → GHR=4'b0111. A 4th cycle holds stall_if=1 → GHR unchanged. Then upd_mispredict with upd_ghr=4'b0001, upd_taken=0, in the same cycle as an IF branch → GHR=4'b0010.
4. JAL and JALR: op_jal with pc 0x200, j_imm 0xFFFFFFF0 → pred_valid=1, pred_is_br=0, target 0x1F0, GHR unchanged. op_jalr → all pred_* outputs 0.
5. Accuracy: 10 updates, 3 with mispredict=1 → c_total=10, c_correct=7. Assert rst=0 mid-stream → both counters 0, ready drops to 0 and the sweep restarts.
6. Read/write collision: update idx 9 (counter 1→2) while the IF index is also 9 → pred_taken=0 that cycle, 1 the next cycle.

Source files
------------

// File: rtl/brp_gshare.sv
// brp_gshare: bimodal/gshare branch predictor with a speculative global history register,
//   restore on mispredict, a table-init sweep after reset, and saturating accuracy counters.
// Latency: predictions are combinational in the IF cycle. Table, GHR and counter updates
//   take effect at the next clock edge.
// Backpressure: stall_if blocks the speculative GHR shift. Updates are never refused; during
//   the init sweep, table updates are dropped.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   pc_if, opcode_if, b_imm,      IF-stage instruction and its offsets
//   j_imm, stall_if
//   ready                         init sweep finished
//   pred_*                        same-cycle prediction, plus idx/ghr carried down the pipe
//   upd_*                         EX-stage resolution (carried idx/ghr, outcome, mispredict)
//   c_total, c_correct            saturating resolved / correctly predicted counts
module brp_gshare #(
  parameter int IDX_BITS  = 6,
  parameter int HIST_BITS = 6,
  parameter int CTR_BITS  = 2,
  parameter int MODE      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_if,
  input  logic [6:0]           opcode_if,
  input  logic [31:0]          b_imm,
  input  logic [31:0]          j_imm,
  input  logic                 stall_if,
  output logic                 ready,
  output logic                 pred_valid,
  output logic                 pred_is_br,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [31:0]          pred_alt,
  output logic [IDX_BITS-1:0]  pred_idx,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [IDX_BITS-1:0]  upd_idx,
  input  logic [HIST_BITS-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  output logic [31:0]          c_total,
  output logic [31:0]          c_correct
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  // Weakly-not-taken: all ones below the MSB.
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   sweep_q, sweep_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [HIST_BITS-1:0]  ghr_shift, ghr_restore;
  logic [31:0]           c_total_q, c_total_d;
  logic [31:0]           c_correct_q, c_correct_d;
  logic [CTR_BITS-1:0]   tbl_q [DEPTH];

  logic                  run;
  logic                  is_br, is_jal;
  logic [IDX_BITS-1:0]   pc_idx, idx;
  logic [CTR_BITS-1:0]   rd_ctr;
  logic                  br_taken;
  logic [31:0]           pc_seq, br_tgt, jal_tgt;
  logic [CTR_BITS-1:0]   ctr_cur, ctr_upd;
  // The oldest carried history bit falls off the end on restore.
  logic                  unused_ghr_msb;

  assign unused_ghr_msb = upd_ghr[HIST_BITS-1];

  // ---------------- FSM: state register / next state / outputs ----------------
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && sweep_q == {IDX_BITS{1'b1}}) state_d = S_RUN;
  end

  always_comb begin
    run   = (state_q == S_RUN);
    ready = run;
  end

  // Sweep pointer wraps back to 0 as the last entry is written.
  always_comb begin
    sweep_d = sweep_q;
    if (state_q == S_INIT) sweep_d = sweep_q + IDX_BITS'(1);
  end

  // ---------------- Index and prediction ----------------
  assign pc_idx = pc_if[IDX_BITS+1:2];

  generate
    if (MODE == 1) begin : g_gshare
      logic [IDX_BITS-1:0] ghr_ext;
      assign ghr_ext = IDX_BITS'(ghr_q);
      assign idx     = pc_idx ^ ghr_ext;
    end else begin : g_bimodal
      assign idx = pc_idx;
    end
  endgenerate

  assign is_br    = (opcode_if == OP_BR);
  assign is_jal   = (opcode_if == OP_JAL);
  assign rd_ctr   = tbl_q[idx];
  // Table contents are not trusted until the sweep is done.
  assign br_taken = run & rd_ctr[CTR_BITS-1];
  assign pc_seq   = pc_if + 32'd4;
  assign br_tgt   = pc_if + b_imm;
  assign jal_tgt  = pc_if + j_imm;

  always_comb begin
    pred_valid  = 1'b0;
    pred_is_br  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    pred_alt    = 32'd0;
    if (is_br) begin
      pred_valid  = 1'b1;
      pred_is_br  = 1'b1;
      pred_taken  = br_taken;
      pred_target = br_taken ? br_tgt : pc_seq;
      pred_alt    = br_taken ? pc_seq : br_tgt;
    end else if (is_jal) begin
      pred_valid  = 1'b1;
      pred_taken  = 1'b1;
      pred_target = jal_tgt;
      pred_alt    = pc_seq;
    end
  end

  assign pred_idx = idx;
  assign pred_ghr = ghr_q;

  // ---------------- Global history ----------------
  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shift   = br_taken;
      assign ghr_restore = upd_taken;
    end else begin : g_histn
      assign ghr_shift   = {ghr_q[HIST_BITS-2:0], br_taken};
      assign ghr_restore = {upd_ghr[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  // A mispredict rewinds to the history the branch saw plus its real outcome,
  // which supersedes whatever IF is speculating this cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (upd_valid && upd_mispredict) ghr_d = ghr_restore;
      else if (is_br && !stall_if)     ghr_d = ghr_shift;
    end
  end

  // ---------------- Counter table ----------------
  always_comb begin
    ctr_cur = tbl_q[upd_idx];
    ctr_upd = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_upd = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_upd = ctr_cur - CTR_BITS'(1);
    end
  end

  // Reads see the pre-edge value; no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run)           tbl_q[sweep_q] <= CTR_WNT;
      else if (upd_valid) tbl_q[upd_idx] <= ctr_upd;
    end
  end

  // ---------------- Accuracy counters ----------------
  always_comb begin
    c_total_d   = c_total_q;
    c_correct_d = c_correct_q;
    if (upd_valid) begin
      if (c_total_q != 32'hFFFF_FFFF) c_total_d = c_total_q + 32'd1;
      if (!upd_mispredict && c_correct_q != 32'hFFFF_FFFF) c_correct_d = c_correct_q + 32'd1;
    end
  end

  assign c_total   = c_total_q;
  assign c_correct = c_correct_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sweep_q     <= '0;
      ghr_q       <= '0;
      c_total_q   <= 32'd0;
      c_correct_q <= 32'd0;
    end else begin
      sweep_q     <= sweep_d;
      ghr_q       <= ghr_d;
      c_total_q   <= c_total_d;
      c_correct_q <= c_correct_d;
    end
  end

endmodule
